// File: rtl/lsu_load_align_wb.sv
// Load writeback stage: aligns and extends a memory word, flags misaligned or
// illegal loads, and buffers results in a 2-entry queue toward the regfile.
module lsu_load_align_wb #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int OFF_W   = $clog2(XLEN/8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_is_load,
  input  logic [XLEN-1:0]    in_data,
  input  logic [OFF_W-1:0]   in_offset,
  input  logic [1:0]         in_size,
  input  logic               in_zero_ext,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]    wb_data,
  output logic               wb_err,
  output logic [1:0]         wb_err_code
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

  typedef struct packed {
    logic               we;
    logic               err;
    logic [1:0]         code;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    data;
  } entry_t;

  logic [2:0]      off_ext;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] ext_data;
  logic            sign_bit;
  logic            illegal;
  logic            misaligned;
  entry_t          new_entry;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       head_q;
  logic       head_d;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       push;
  logic       pop;
  logic       tail;
  entry_t     head_entry;

  // The offset is widened to 3 bits so the D alignment check is uniform;
  // for XLEN=32 the top bit is simply zero.
  always_comb begin
    off_ext = 3'(in_offset);
    shifted = in_data >> {in_offset, 3'b000};

    size_mask = '1;
    sign_bit  = 1'b0;
    case (in_size)
      SZ_B: begin
        size_mask = XLEN'(64'h0000_0000_0000_00FF);
        sign_bit  = shifted[7];
      end
      SZ_H: begin
        size_mask = XLEN'(64'h0000_0000_0000_FFFF);
        sign_bit  = shifted[15];
      end
      SZ_W: begin
        size_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
        sign_bit  = shifted[31];
      end
      default: begin
        size_mask = '1;
        sign_bit  = 1'b0;
      end
    endcase

    // Sign fill lands only above the access width; when the access is as
    // wide as XLEN the inverted mask is zero and the word passes through.
    ext_data = shifted & size_mask;
    if (sign_bit && !in_zero_ext) begin
      ext_data = ext_data | ~size_mask;
    end
  end

  always_comb begin
    illegal = ((in_size == SZ_D) && ((XLEN == 32) || in_zero_ext)) ||
              ((in_size == SZ_W) && in_zero_ext && (XLEN == 32));

    misaligned = 1'b0;
    case (in_size)
      SZ_H:    misaligned = off_ext[0] != 1'b0;
      SZ_W:    misaligned = off_ext[1:0] != 2'b00;
      SZ_D:    misaligned = off_ext != 3'b000;
      default: misaligned = 1'b0;
    endcase
  end

  // Illegal outranks misaligned; error entries carry no data and never write.
  always_comb begin
    new_entry.rd   = in_rd;
    new_entry.we   = 1'b0;
    new_entry.err  = 1'b0;
    new_entry.code = ERR_NONE;
    new_entry.data = '0;
    if (illegal) begin
      new_entry.err  = 1'b1;
      new_entry.code = ERR_ILLEGAL;
    end else if (misaligned) begin
      new_entry.err  = 1'b1;
      new_entry.code = ERR_MISALIGN;
    end else begin
      new_entry.we   = in_rd != '0;
      new_entry.data = ext_data;
    end
  end

  // in_ready depends on count_q alone, so back-pressure never forms a
  // combinational path from wb_ready.
  always_comb begin
    in_ready = count_q != 2'd2;
    wb_valid = count_q != 2'd0;
    push     = in_valid && in_ready && in_is_load;
    pop      = wb_valid && wb_ready;
    tail     = head_q ^ (count_q == 2'd1);
  end

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push) begin
      mem_d[tail] = new_entry;
    end
    head_d  = pop ? ~head_q : head_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  // Write enable and error flags are qualified by wb_valid so a stale head
  // never looks like a live write; rd/data keep showing the last head.
  always_comb begin
    head_entry  = mem_q[head_q];
    wb_we       = wb_valid && head_entry.we;
    wb_err      = wb_valid && head_entry.err;
    wb_err_code = wb_valid ? head_entry.code : ERR_NONE;
    wb_rd       = head_entry.rd;
    wb_data     = head_entry.data;
  end

endmodule

// File: tb/tb_lsu_load_align_wb.sv
// Bench for lsu_load_align_wb: directed vector table, multi-cycle corner
// sequences and random traffic on XLEN=32 and XLEN=64 instances.
module tb_lsu_load_align_wb;

  typedef struct {
    logic       we;
    logic       err;
    logic [1:0] code;
    logic [4:0] rd;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    bit          is64;
    logic [1:0]  size;
    logic [2:0]  off;
    logic        zext;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        exp_we;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [63:0] exp_data;
  } vec_t;

  localparam int NVEC = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid_32, in_ready_32, in_is_load_32, in_zero_ext_32;
  logic [31:0] in_data_32;
  logic [1:0]  in_offset_32, in_size_32;
  logic [4:0]  in_rd_32;
  logic        wb_valid_32, wb_ready_32, wb_we_32, wb_err_32;
  logic [4:0]  wb_rd_32;
  logic [31:0] wb_data_32;
  logic [1:0]  wb_err_code_32;

  logic        in_valid_64, in_ready_64, in_is_load_64, in_zero_ext_64;
  logic [63:0] in_data_64;
  logic [2:0]  in_offset_64;
  logic [1:0]  in_size_64;
  logic [4:0]  in_rd_64;
  logic        wb_valid_64, wb_ready_64, wb_we_64, wb_err_64;
  logic [4:0]  wb_rd_64;
  logic [63:0] wb_data_64;
  logic [1:0]  wb_err_code_64;

  lsu_load_align_wb #(.XLEN(32), .RADDR_W(5)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_32), .in_ready(in_ready_32), .in_is_load(in_is_load_32),
    .in_data(in_data_32), .in_offset(in_offset_32), .in_size(in_size_32),
    .in_zero_ext(in_zero_ext_32), .in_rd(in_rd_32),
    .wb_valid(wb_valid_32), .wb_ready(wb_ready_32), .wb_we(wb_we_32),
    .wb_rd(wb_rd_32), .wb_data(wb_data_32), .wb_err(wb_err_32),
    .wb_err_code(wb_err_code_32)
  );

  lsu_load_align_wb #(.XLEN(64), .RADDR_W(5)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_64), .in_ready(in_ready_64), .in_is_load(in_is_load_64),
    .in_data(in_data_64), .in_offset(in_offset_64), .in_size(in_size_64),
    .in_zero_ext(in_zero_ext_64), .in_rd(in_rd_64),
    .wb_valid(wb_valid_64), .wb_ready(wb_ready_64), .wb_we(wb_we_64),
    .wb_rd(wb_rd_64), .wb_data(wb_data_64), .wb_err(wb_err_64),
    .wb_err_code(wb_err_code_64)
  );

  int   n_vec = 0;
  int   n_miss = 0;
  bit   sb_en = 1'b0;
  int   outs32 = 0;
  int   outs64 = 0;
  exp_t q32[$];
  exp_t q64[$];
  vec_t vecs[NVEC];

  function automatic void compare(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Reference model: extract the access bytes with plain shifts and masks,
  // then apply the legality rules in priority order.
  function automatic exp_t model_load(int xlen, logic [1:0] size, logic [2:0] off,
                                      logic zext, logic [4:0] rd, logic [63:0] data);
    exp_t        e;
    int          nbytes;
    int          nbits;
    logic [63:0] sh;
    logic [63:0] lowmask;
    logic [63:0] v;
    nbytes = 1 << size;
    nbits  = 8 * nbytes;
    e.rd   = rd;
    e.we   = 1'b0;
    e.err  = 1'b0;
    e.code = 2'd0;
    e.data = 64'd0;
    if ((size == 2'd3 && (xlen == 32 || zext)) || (size == 2'd2 && zext && xlen == 32)) begin
      e.err  = 1'b1;
      e.code = 2'd2;
    end else if ((int'(off) % nbytes) != 0) begin
      e.err  = 1'b1;
      e.code = 2'd1;
    end else begin
      sh      = data >> (8 * int'(off));
      lowmask = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
      v       = sh & lowmask;
      if (!zext && nbits < 64 && v[nbits-1]) v = v | ~lowmask;
      if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      e.data = v;
      e.we   = rd != 5'd0;
    end
    return e;
  endfunction

  function automatic void sb_common(string tag, int qsize, logic rdy, logic vld);
    compare({tag, ".in_ready"}, 64'(rdy), 64'(qsize != 2));
    compare({tag, ".wb_valid"}, 64'(vld), 64'(qsize != 0));
  endfunction

  function automatic void sb_head(string tag, exp_t h, logic we, logic err, logic [1:0] code,
                                  logic [4:0] rd, logic [63:0] data);
    compare({tag, ".wb_we"}, 64'(we), 64'(h.we));
    compare({tag, ".wb_err"}, 64'(err), 64'(h.err));
    compare({tag, ".wb_err_code"}, 64'(code), 64'(h.code));
    compare({tag, ".wb_rd"}, 64'(rd), 64'(h.rd));
    compare({tag, ".wb_data"}, data, h.data);
  endfunction

  function automatic void sb_idle(string tag, logic we, logic err, logic [1:0] code);
    compare({tag, ".idle_we"}, 64'(we), 64'd0);
    compare({tag, ".idle_err"}, 64'(err), 64'd0);
    compare({tag, ".idle_code"}, 64'(code), 64'd0);
  endfunction

  // Scoreboard bookkeeping: pop on output transfer, then push on input load.
  always @(posedge clk) begin
    if (rst) begin
      q32.delete();
      q64.delete();
      sb_en <= 1'b1;
    end else if (sb_en) begin
      int c32;
      int c64;
      c32 = q32.size();
      c64 = q64.size();
      if (c32 != 0 && wb_ready_32) begin
        void'(q32.pop_front());
        outs32 <= outs32 + 1;
      end
      if (in_valid_32 && c32 != 2 && in_is_load_32)
        q32.push_back(model_load(32, in_size_32, 3'(in_offset_32), in_zero_ext_32,
                                 in_rd_32, 64'(in_data_32)));
      if (c64 != 0 && wb_ready_64) begin
        void'(q64.pop_front());
        outs64 <= outs64 + 1;
      end
      if (in_valid_64 && c64 != 2 && in_is_load_64)
        q64.push_back(model_load(64, in_size_64, in_offset_64, in_zero_ext_64,
                                 in_rd_64, in_data_64));
    end
  end

  always @(negedge clk) begin
    if (sb_en) begin
      sb_common("d32", q32.size(), in_ready_32, wb_valid_32);
      if (q32.size() != 0)
        sb_head("d32", q32[0], wb_we_32, wb_err_32, wb_err_code_32, wb_rd_32, 64'(wb_data_32));
      else
        sb_idle("d32", wb_we_32, wb_err_32, wb_err_code_32);
      sb_common("d64", q64.size(), in_ready_64, wb_valid_64);
      if (q64.size() != 0)
        sb_head("d64", q64[0], wb_we_64, wb_err_64, wb_err_code_64, wb_rd_64, wb_data_64);
      else
        sb_idle("d64", wb_we_64, wb_err_64, wb_err_code_64);
    end
  end

  task automatic drive(input bit is64, input logic v, input logic ld, input logic [1:0] size,
                       input logic [2:0] off, input logic zext, input logic [4:0] rd,
                       input logic [63:0] data);
    if (is64) begin
      in_valid_64 = v; in_is_load_64 = ld; in_size_64 = size; in_offset_64 = off;
      in_zero_ext_64 = zext; in_rd_64 = rd; in_data_64 = data;
    end else begin
      in_valid_32 = v; in_is_load_32 = ld; in_size_32 = size; in_offset_32 = off[1:0];
      in_zero_ext_32 = zext; in_rd_32 = rd; in_data_32 = data[31:0];
    end
  endtask

  task automatic idle(input bit is64);
    drive(is64, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 5'd0, 64'd0);
  endtask

  // Present one request and hold it until accepted or the cycle budget expires.
  task automatic send_wait(input bit is64, input logic ld, input logic [1:0] size,
                           input logic [2:0] off, input logic zext, input logic [4:0] rd,
                           input logic [63:0] data, input int limit, output bit ok);
    int guard;
    guard = 0;
    drive(is64, 1'b1, ld, size, off, zext, rd, data);
    while (!(is64 ? in_ready_64 : in_ready_32) && guard < limit) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = is64 ? in_ready_64 : in_ready_32;
    if (ok) begin
      @(posedge clk); #1;
    end
    idle(is64);
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.is64, 1'b1, 1'b1, v.size, v.off, v.zext, v.rd, v.data);
    @(posedge clk); #1;
    idle(v.is64);
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    if (v.is64) begin
      compare({t, ".valid"}, 64'(wb_valid_64), 64'd1);
      compare({t, ".we"}, 64'(wb_we_64), 64'(v.exp_we));
      compare({t, ".err"}, 64'(wb_err_64), 64'(v.exp_err));
      compare({t, ".code"}, 64'(wb_err_code_64), 64'(v.exp_code));
      compare({t, ".rd"}, 64'(wb_rd_64), 64'(v.rd));
      compare({t, ".data"}, wb_data_64, v.exp_data);
    end else begin
      compare({t, ".valid"}, 64'(wb_valid_32), 64'd1);
      compare({t, ".we"}, 64'(wb_we_32), 64'(v.exp_we));
      compare({t, ".err"}, 64'(wb_err_32), 64'(v.exp_err));
      compare({t, ".code"}, 64'(wb_err_code_32), 64'(v.exp_code));
      compare({t, ".rd"}, 64'(wb_rd_32), 64'(v.rd));
      compare({t, ".data"}, 64'(wb_data_32), v.exp_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int base;
    int guard;

    //          is64  size   off    zext  rd     data                    we    err   code   exp_data
    vecs[0]  = '{1'b0, 2'd0, 3'd3, 1'b0, 5'd5,  64'h0000_0000_80AA_BBCC, 1'b1, 1'b0, 2'd0, 64'h0000_0000_FFFF_FF80};
    vecs[1]  = '{1'b0, 2'd0, 3'd3, 1'b1, 5'd5,  64'h0000_0000_80AA_BBCC, 1'b1, 1'b0, 2'd0, 64'h0000_0000_0000_0080};
    vecs[2]  = '{1'b0, 2'd1, 3'd1, 1'b0, 5'd7,  64'h0000_0000_80AA_BBCC, 1'b0, 1'b1, 2'd1, 64'h0};
    vecs[3]  = '{1'b0, 2'd3, 3'd0, 1'b0, 5'd8,  64'h0000_0000_80AA_BBCC, 1'b0, 1'b1, 2'd2, 64'h0};
    vecs[4]  = '{1'b0, 2'd2, 3'd0, 1'b1, 5'd9,  64'h0000_0000_80AA_BBCC, 1'b0, 1'b1, 2'd2, 64'h0};
    vecs[5]  = '{1'b0, 2'd2, 3'd0, 1'b0, 5'd3,  64'h0000_0000_9234_5678, 1'b1, 1'b0, 2'd0, 64'h0000_0000_9234_5678};
    vecs[6]  = '{1'b0, 2'd1, 3'd2, 1'b0, 5'd4,  64'h0000_0000_80AA_BBCC, 1'b1, 1'b0, 2'd0, 64'h0000_0000_FFFF_80AA};
    vecs[7]  = '{1'b0, 2'd0, 3'd0, 1'b0, 5'd0,  64'h0000_0000_80AA_BBCC, 1'b0, 1'b0, 2'd0, 64'h0000_0000_FFFF_FFCC};
    vecs[8]  = '{1'b0, 2'd3, 3'd1, 1'b0, 5'd6,  64'h0000_0000_80AA_BBCC, 1'b0, 1'b1, 2'd2, 64'h0};
    vecs[9]  = '{1'b0, 2'd1, 3'd2, 1'b1, 5'd2,  64'h0000_0000_80AA_BBCC, 1'b1, 1'b0, 2'd0, 64'h0000_0000_0000_80AA};
    vecs[10] = '{1'b1, 2'd2, 3'd4, 1'b1, 5'd9,  64'h8765_4321_0000_0000, 1'b1, 1'b0, 2'd0, 64'h0000_0000_8765_4321};
    vecs[11] = '{1'b1, 2'd3, 3'd0, 1'b0, 5'd10, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 2'd0, 64'h0123_4567_89AB_CDEF};
    vecs[12] = '{1'b1, 2'd3, 3'd4, 1'b0, 5'd11, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 2'd1, 64'h0};
    vecs[13] = '{1'b1, 2'd2, 3'd4, 1'b0, 5'd12, 64'h8765_4321_0000_0000, 1'b1, 1'b0, 2'd0, 64'hFFFF_FFFF_8765_4321};
    vecs[14] = '{1'b1, 2'd3, 3'd0, 1'b1, 5'd13, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 2'd2, 64'h0};
    vecs[15] = '{1'b1, 2'd1, 3'd6, 1'b0, 5'd14, 64'h8001_0000_0000_0000, 1'b1, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_8001};
    vecs[16] = '{1'b1, 2'd1, 3'd7, 1'b0, 5'd15, 64'h8001_0000_0000_0000, 1'b0, 1'b1, 2'd1, 64'h0};
    vecs[17] = '{1'b1, 2'd0, 3'd5, 1'b0, 5'd16, 64'h0000_AB00_0000_0000, 1'b1, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB};

    rst = 1'b1;
    idle(1'b0);
    idle(1'b1);
    wb_ready_32 = 1'b1;
    wb_ready_64 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    compare("rst.valid32", 64'(wb_valid_32), 64'd0);
    compare("rst.we32", 64'(wb_we_32), 64'd0);
    compare("rst.err32", 64'(wb_err_32), 64'd0);
    compare("rst.code32", 64'(wb_err_code_32), 64'd0);
    compare("rst.rd32", 64'(wb_rd_32), 64'd0);
    compare("rst.data32", 64'(wb_data_32), 64'd0);
    compare("rst.ready32", 64'(in_ready_32), 64'd1);
    compare("rst.valid64", 64'(wb_valid_64), 64'd0);
    compare("rst.data64", wb_data_64, 64'd0);
    compare("rst.ready64", 64'(in_ready_64), 64'd1);

    $display("[TB] directed vectors");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    $display("[TB] back-pressure");
    wb_ready_32 = 1'b0;
    send_wait(1'b0, 1'b1, 2'd0, 3'd0, 1'b1, 5'd1, 64'h11, 4, ok);
    compare("bp.acceptA", 64'(ok), 64'd1);
    send_wait(1'b0, 1'b1, 2'd0, 3'd1, 1'b1, 5'd2, 64'h2200, 4, ok);
    compare("bp.acceptB", 64'(ok), 64'd1);
    drive(1'b0, 1'b1, 1'b1, 2'd0, 3'd2, 1'b1, 5'd3, 64'h33_0000);
    for (int k = 0; k < 3; k++) begin
      compare("bp.ready_low", 64'(in_ready_32), 64'd0);
      compare("bp.hold_data", 64'(wb_data_32), 64'h11);
      compare("bp.hold_rd", 64'(wb_rd_32), 64'd1);
      @(posedge clk); #1;
    end
    base = outs32;
    wb_ready_32 = 1'b1;
    send_wait(1'b0, 1'b1, 2'd0, 3'd2, 1'b1, 5'd3, 64'h33_0000, 4, ok);
    compare("bp.acceptC", 64'(ok), 64'd1);
    guard = 0;
    while (wb_valid_32 && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    compare("bp.drained", 64'(outs32 - base), 64'd3);
    compare("bp.ready_back", 64'(in_ready_32), 64'd1);

    $display("[TB] streaming");
    base = outs32;
    for (int k = 0; k < 8; k++) begin
      send_wait(1'b0, 1'b1, 2'd0, 3'(k % 4), 1'b0, 5'(k + 1), 64'(32'hF0E1_D2C3 + k), 1, ok);
      compare("stream.accept", 64'(ok), 64'd1);
    end
    @(posedge clk); #1;
    compare("stream.outputs", 64'(outs32 - base), 64'd8);

    $display("[TB] store/nop interleave");
    base = outs64;
    send_wait(1'b1, 1'b1, 2'd3, 3'd0, 1'b0, 5'd20, 64'hAAAA_BBBB_CCCC_DDDD, 4, ok);
    send_wait(1'b1, 1'b0, 2'd3, 3'd0, 1'b0, 5'd21, 64'h1111_1111_1111_1111, 4, ok);
    send_wait(1'b1, 1'b1, 2'd1, 3'd2, 1'b1, 5'd22, 64'h0000_0000_BEEF_0000, 4, ok);
    send_wait(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 5'd0, 64'h0, 4, ok);
    send_wait(1'b1, 1'b1, 2'd0, 3'd1, 1'b0, 5'd0, 64'h0000_0000_0000_7F00, 4, ok);
    repeat (3) @(posedge clk);
    #1;
    compare("interleave.outputs", 64'(outs64 - base), 64'd3);

    $display("[TB] reset with full queue");
    wb_ready_64 = 1'b0;
    send_wait(1'b1, 1'b1, 2'd2, 3'd0, 1'b0, 5'd1, 64'h1234_5678, 4, ok);
    send_wait(1'b1, 1'b1, 2'd2, 3'd4, 1'b0, 5'd2, 64'h1234_5678_0000_0000, 4, ok);
    compare("rstq.full", 64'(in_ready_64), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    compare("rstq.valid", 64'(wb_valid_64), 64'd0);
    compare("rstq.ready", 64'(in_ready_64), 64'd1);
    wb_ready_64 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      compare("rstq.no_stale", 64'(wb_valid_64), 64'd0);
    end

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      drive(1'b0, 1'($urandom), 1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 7)), 64'($urandom));
      drive(1'b1, 1'($urandom), 1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      wb_ready_32 = 1'($urandom_range(0, 3) != 0);
      wb_ready_64 = 1'($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    idle(1'b0);
    idle(1'b1);
    wb_ready_32 = 1'b1;
    wb_ready_64 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    compare("final.empty32", 64'(wb_valid_32), 64'd0);
    compare("final.empty64", 64'(wb_valid_64), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
